horner_poly_eval: RTL and testbench

//   Parametrised FSM+datapath evaluator of y = c[D]*x^D + ... + c[1]*x + c[0].

---
 rtl/horner_poly_eval_pkg.sv | 25 ++
 rtl/horner_poly_eval_alu.sv | 21 ++
 rtl/horner_poly_eval.sv | 123 ++++++++++++
 tb/tb_horner_poly_eval.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/horner_poly_eval_pkg.sv
// Shared state encodings, ALU op codes and decode helpers for the Horner evaluator.
package horner_poly_eval_pkg;

    typedef enum logic [2:0] {
        LOAD_C      = 3'd0,
        LOAD_C_WAIT = 3'd1,
        LOAD_X      = 3'd2,
        LOAD_X_WAIT = 3'd3,
        CALC_INIT   = 3'd4,
        CALC_MUL    = 3'd5,
        CALC_ADD    = 3'd6,
        CALC_DONE   = 3'd7
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } alu_op_t;

    // All CALC_* encodings share the top bit.
    function automatic logic is_calc(input state_t s);
        return s[2];
    endfunction

endpackage

// File: rtl/horner_poly_eval_alu.sv
// Shared add/multiply ALU; result truncated to WIDTH.
// Latency: combinational. Backpressure: none.
// Operands are consumed and produced in the same cycle.
module horner_poly_eval_alu
    import horner_poly_eval_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        if (op == OP_MUL) y = a * b;
        else              y = a + b;
    end

endmodule

// File: rtl/horner_poly_eval.sv
// Polynomial evaluator y = sum c[i]*x^i by Horner's rule on one shared ALU.
// Latency: done rises 2*DEGREE+2 cycles after the x release; data_result follows one cycle later.
// Backpressure: none; operator press/release handshake on go, go ignored while busy.
module horner_poly_eval
    import horner_poly_eval_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 3
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        go,
    input  logic [WIDTH-1:0]            data_in,
    output logic [$clog2(DEGREE+2)-1:0] coef_idx,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            data_result
);

    localparam int IDX_W = $clog2(DEGREE+2);
    localparam int CW    = $clog2(DEGREE+1);
    localparam logic [IDX_W-1:0] K_TOP  = IDX_W'(DEGREE);
    localparam logic [IDX_W-1:0] K_X    = IDX_W'(DEGREE+1);
    localparam logic [IDX_W-1:0] K_NEXT = IDX_W'(DEGREE-1);

    state_t           state;
    logic [IDX_W-1:0] k;
    logic [CW-1:0]    kc;
    logic [WIDTH-1:0] coef [0:DEGREE];
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;
    alu_op_t          alu_op;

    assign kc = k[CW-1:0];

    always_comb begin
        alu_op = OP_ADD;
        alu_b  = coef[kc];
        if (state == CALC_MUL) begin
            alu_op = OP_MUL;
            alu_b  = x;
        end
    end

    horner_poly_eval_alu #(.WIDTH(WIDTH)) u_alu (
        .op (alu_op),
        .a  (acc),
        .b  (alu_b),
        .y  (alu_y)
    );

    assign coef_idx = (state == LOAD_X || state == LOAD_X_WAIT) ? K_X : k;
    assign busy     = is_calc(state);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= LOAD_C;
            k           <= K_TOP;
            x           <= '0;
            acc         <= '0;
            done        <= 1'b0;
            data_result <= '0;
            for (int i = 0; i <= DEGREE; i++) coef[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD_C: begin
                    coef[kc] <= data_in;
                    if (go) state <= LOAD_C_WAIT;
                end
                LOAD_C_WAIT: begin
                    if (!go) begin
                        if (k == '0) begin
                            state <= LOAD_X;
                        end else begin
                            k     <= k - 1'b1;
                            state <= LOAD_C;
                        end
                    end
                end
                LOAD_X: begin
                    x <= data_in;
                    if (go) state <= LOAD_X_WAIT;
                end
                LOAD_X_WAIT: begin
                    if (!go) state <= CALC_INIT;
                end
                CALC_INIT: begin
                    acc   <= coef[DEGREE];
                    k     <= K_NEXT;
                    state <= CALC_MUL;
                end
                CALC_MUL: begin
                    acc   <= alu_y;
                    state <= CALC_ADD;
                end
                CALC_ADD: begin
                    acc <= alu_y;
                    if (k == '0) begin
                        // done is registered so it is high exactly while in CALC_DONE
                        state <= CALC_DONE;
                        done  <= 1'b1;
                    end else begin
                        k     <= k - 1'b1;
                        state <= CALC_MUL;
                    end
                end
                CALC_DONE: begin
                    data_result <= acc;
                    k           <= K_TOP;
                    state       <= LOAD_C;
                end
                default: begin
                    k     <= K_TOP;
                    state <= LOAD_C;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_horner_poly_eval.sv
// Directed bench for horner_poly_eval: 8-bit/degree-3 and 16-bit/degree-5 instances.
module tb_horner_poly_eval;

    localparam int IW8  = $clog2(3+2);
    localparam int IW16 = $clog2(5+2);

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             go8 = 1'b0;
    logic [7:0]       data8 = '0;
    logic [IW8-1:0]   coef_idx8;
    logic             busy8, done8;
    logic [7:0]       res8;
    logic             go16 = 1'b0;
    logic [15:0]      data16 = '0;
    logic [IW16-1:0]  coef_idx16;
    logic             busy16, done16;
    logic [15:0]      res16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    horner_poly_eval #(.WIDTH(8), .DEGREE(3)) dut8 (
        .clk(clk), .resetn(resetn), .go(go8), .data_in(data8),
        .coef_idx(coef_idx8), .busy(busy8), .done(done8), .data_result(res8)
    );

    horner_poly_eval #(.WIDTH(16), .DEGREE(5)) dut16 (
        .clk(clk), .resetn(resetn), .go(go16), .data_in(data16),
        .coef_idx(coef_idx16), .busy(busy16), .done(done16), .data_result(res16)
    );

    task automatic press8(input logic [7:0] v);
        @(negedge clk);
        data8 = v;
        go8   = 1'b1;
        @(negedge clk);
        go8   = 1'b0;
    endtask

    // x press/release, then watch 30 cycles for done; lat stays -1 if done never comes
    task automatic finish8(input logic [7:0] xv, input bit go_calc,
                           output int lat, output int npulse, output logic [7:0] res_at_done);
        @(negedge clk);
        data8 = xv;
        go8   = 1'b1;
        checks++;
        if (coef_idx8 !== 3'd4) begin
            errors++;
            $display("FAIL coef_idx_x: got %0d expected 4", coef_idx8);
        end
        @(negedge clk);
        go8 = 1'b0;
        lat = -1;
        npulse = 0;
        res_at_done = 'x;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                npulse++;
                if (lat < 0) begin
                    lat = i;
                    res_at_done = res8;
                end
            end
            if (go_calc && i == 2) go8 = 1'b1;
            if (go_calc && i == 5) go8 = 1'b0;
        end
    endtask

    task automatic run8(input logic [7:0] c3, c2, c1, c0, xv, input bit go_calc,
                        output int lat, output int npulse, output logic [7:0] res_at_done);
        press8(c3);
        press8(c2);
        press8(c1);
        press8(c0);
        finish8(xv, go_calc, lat, npulse, res_at_done);
    endtask

    task automatic check_run(input string name, input int lat, input int npulse,
                             input logic [7:0] exp_res, input int exp_lat);
        checks++;
        if (res8 !== exp_res) begin
            errors++;
            $display("FAIL %s_result: got %0d expected %0d", name, res8, exp_res);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (npulse !== 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d expected 1", name, npulse);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        checks++;
        if (coef_idx8 !== 3'd3 || busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'd0) begin
            errors++;
            $display("FAIL reset8: got idx=%0d busy=%0b done=%0b res=%0d expected 3 0 0 0",
                     coef_idx8, busy8, done8, res8);
        end
        checks++;
        if (coef_idx16 !== 3'd5 || busy16 !== 1'b0 || done16 !== 1'b0 || res16 !== 16'd0) begin
            errors++;
            $display("FAIL reset16: got idx=%0d busy=%0b done=%0b res=%0d expected 5 0 0 0",
                     coef_idx16, busy16, done16, res16);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        int lat, np;
        logic [7:0] rd;
        run8(8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 1'b0, lat, np, rd);
        check_run("basic", lat, np, 8'h1A, 8);
    endtask

    task automatic test_second_run();
        int lat, np;
        logic [7:0] rd;
        run8(8'd0, 8'd0, 8'd1, 8'd7, 8'd3, 1'b0, lat, np, rd);
        checks++;
        if (rd !== 8'd26) begin
            errors++;
            $display("FAIL second_hold_prev: got %0d expected 26", rd);
        end
        check_run("second", lat, np, 8'h0A, 8);
    endtask

    task automatic test_wrap();
        int lat, np;
        logic [7:0] rd;
        run8(8'd1, 8'd0, 8'd0, 8'd0, 8'd16, 1'b0, lat, np, rd);
        check_run("wrap", lat, np, 8'h00, 8);
    endtask

    task automatic test_go_hold();
        int lat, np;
        logic [7:0] rd;
        @(negedge clk);
        data8 = 8'd5;
        go8   = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (coef_idx8 !== 3'd3) begin
            errors++;
            $display("FAIL hold_idx: got %0d expected 3", coef_idx8);
        end
        go8 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (coef_idx8 !== 3'd2) begin
            errors++;
            $display("FAIL hold_release_idx: got %0d expected 2", coef_idx8);
        end
        press8(8'd0);
        press8(8'd0);
        press8(8'd0);
        finish8(8'd1, 1'b0, lat, np, rd);
        check_run("hold", lat, np, 8'd5, 8);
    endtask

    task automatic test_go_during_calc();
        int lat, np;
        logic [7:0] rd;
        run8(8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 1'b1, lat, np, rd);
        check_run("go_calc", lat, np, 8'd26, 8);
    endtask

    task automatic test_reset_mid_calc();
        int np;
        press8(8'd1);
        press8(8'd2);
        press8(8'd3);
        press8(8'd4);
        @(negedge clk);
        data8 = 8'd2;
        go8   = 1'b1;
        @(negedge clk);
        go8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got %0b expected 1", busy8);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (res8 !== 8'd0 || coef_idx8 !== 3'd3 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got res=%0d idx=%0d busy=%0b done=%0b expected 0 3 0 0",
                     res8, coef_idx8, busy8, done8);
        end
        @(negedge clk);
        resetn = 1'b1;
        np = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done8) np++;
        end
        checks++;
        if (np !== 0 || res8 !== 8'd0) begin
            errors++;
            $display("FAIL abort_no_done: got pulses=%0d res=%0d expected 0 0", np, res8);
        end
    endtask

    task automatic test_wide();
        int lat, np;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            data16 = 16'd1;
            go16   = 1'b1;
            @(negedge clk);
            go16 = 1'b0;
        end
        @(negedge clk);
        data16 = 16'd3;
        go16   = 1'b1;
        checks++;
        if (coef_idx16 !== 3'd6) begin
            errors++;
            $display("FAIL wide_idx_x: got %0d expected 6", coef_idx16);
        end
        @(negedge clk);
        go16 = 1'b0;
        lat = -1;
        np  = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (done16) begin
                np++;
                if (lat < 0) lat = i;
            end
        end
        checks++;
        if (res16 !== 16'h016C) begin
            errors++;
            $display("FAIL wide_result: got %0d expected 364", res16);
        end
        checks++;
        if (lat !== 12 || np !== 1) begin
            errors++;
            $display("FAIL wide_latency: got lat=%0d pulses=%0d expected 12 1", lat, np);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second_run();
        test_wrap();
        test_go_hold();
        test_go_during_calc();
        test_reset_mid_calc();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
